// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared ALU: IDLE -> EXEC -> RESP, one op in flight.
// Define ALU_ARB_RR_EN for round-robin contention; otherwise req0 has fixed priority.
module alu_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    input  logic            req1_valid,
    output logic            req0_ready,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    input  logic [3:0]      req0_ctrl,
    input  logic [3:0]      req1_ctrl,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] alu_result,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [XLEN-1:0] rsp_result,
    output logic [1:0]      state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
    // valid never waits on ready, and ready is only offered to the requester being granted.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic            grant1;
    logic            accept;
    logic [XLEN-1:0] a_q, b_q, res_q;
    logic [3:0]      ctrl_q;
    logic            id_q;

`ifdef ALU_ARB_RR_EN
    logic last_grant;

    // Reset to 1 so the first contention after reset goes to req0.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant1;
        end
    end

    always_comb begin
        grant1 = req1_valid;
        if (req0_valid && req1_valid) begin
            grant1 = ~last_grant;
        end
    end
`else
    always_comb begin
        grant1 = req1_valid && !req0_valid;
    end
`endif

    assign accept = (state == IDLE) && !rst && (req0_valid || req1_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                if (!rst) begin
                    req0_ready = req0_valid && !grant1;
                    req1_ready = req1_valid && grant1;
                end
                if (accept) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            ctrl_q <= 4'b0000;
            id_q   <= 1'b0;
            res_q  <= '0;
        end else begin
            if (accept) begin
                a_q    <= grant1 ? req1_a : req0_a;
                b_q    <= grant1 ? req1_b : req0_b;
                ctrl_q <= grant1 ? req1_ctrl : req0_ctrl;
                id_q   <= grant1;
            end
            if (state == EXEC) begin
                res_q <= alu_result;
            end
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_ctrl   = ctrl_q;
    assign rsp_valid  = (state == RESP);
    assign rsp_id     = id_q;
    assign rsp_result = res_q;
    assign state_dbg  = state;

endmodule
